// File: rtl/rx_freq_sched.sv
// Round-robin scheduler that loads per-channel tuning words into the rx DDCs.
// Each grant runs an H/L strobe pair on a one-hot select and then acks the requester.
module rx_freq_sched #(
    parameter int N_CHANS   = 8,
    parameter int FREQ_BITS = 48,
    parameter int SYNC_TMO  = 1024
) (
    input  logic                           adc_clk,
    input  logic                           rst,
    input  logic [N_CHANS-1:0]             req_A,
    input  logic [N_CHANS*FREQ_BITS-1:0]   freq_A,
    input  logic                           sync_en_A,
    input  logic                           rx_avail_A,
    output logic [N_CHANS-1:0]             rx_sel_A,
    output logic                           set_freqH_A,
    output logic                           set_freqL_A,
    output logic [31:0]                    freq_dout_A,
    output logic [N_CHANS-1:0]             ack_A,
    output logic                           busy_A,
    output logic                           sync_tmo_A
);

    localparam int CW = $clog2(N_CHANS);
    localparam int TW = $clog2(SYNC_TMO);
    localparam logic [N_CHANS-1:0] ONE = N_CHANS'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_WAIT_SYNC, S_LOAD_H, S_LOAD_L, S_ACK
    } state_t;

    state_t                            state;
    logic [CW-1:0]                     last_gnt;
    logic [CW-1:0]                     gnt;
    logic [FREQ_BITS-1:0]              word_q;
    logic [TW-1:0]                     ctr;
    logic [N_CHANS-1:0][FREQ_BITS-1:0] freq_w;

    logic          arb_hit;
    logic [CW-1:0] arb_gnt;
    logic [CW:0]   cand;

    assign freq_w = freq_A;

    // Walk last+N down to last+1 so the nearest requester after last_gnt wins.
    always_comb begin
        arb_hit = 1'b0;
        arb_gnt = '0;
        cand    = '0;
        for (int i = N_CHANS; i >= 1; i--) begin
            cand = {1'b0, last_gnt} + (CW+1)'(i);
            if (cand >= (CW+1)'(N_CHANS))
                cand = cand - (CW+1)'(N_CHANS);
            if (req_A[cand[CW-1:0]]) begin
                arb_hit = 1'b1;
                arb_gnt = cand[CW-1:0];
            end
        end
    end

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            state       <= S_IDLE;
            last_gnt    <= CW'(N_CHANS-1);
            gnt         <= '0;
            word_q      <= '0;
            ctr         <= '0;
            rx_sel_A    <= '0;
            set_freqH_A <= 1'b0;
            set_freqL_A <= 1'b0;
            freq_dout_A <= '0;
            ack_A       <= '0;
            busy_A      <= 1'b0;
            sync_tmo_A  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req_A) begin
                        state  <= S_ARB;
                        busy_A <= 1'b1;
                    end
                end
                S_ARB: begin
                    ctr <= '0;
                    if (!arb_hit) begin
                        state  <= S_IDLE;
                        busy_A <= 1'b0;
                    end else begin
                        gnt    <= arb_gnt;
                        word_q <= freq_w[arb_gnt];
                        if (sync_en_A) begin
                            state <= S_WAIT_SYNC;
                        end else begin
                            state       <= S_LOAD_H;
                            rx_sel_A    <= ONE << arb_gnt;
                            set_freqH_A <= 1'b1;
                            freq_dout_A <= 32'(freq_w[arb_gnt][FREQ_BITS-1:32]);
                        end
                    end
                end
                S_WAIT_SYNC: begin
                    // A strobe on the final count still counts as a sync, not a timeout.
                    if (rx_avail_A || ctr == TW'(SYNC_TMO-1)) begin
                        if (!rx_avail_A)
                            sync_tmo_A <= 1'b1;
                        state       <= S_LOAD_H;
                        rx_sel_A    <= ONE << gnt;
                        set_freqH_A <= 1'b1;
                        freq_dout_A <= 32'(word_q[FREQ_BITS-1:32]);
                    end else begin
                        ctr <= ctr + TW'(1);
                    end
                end
                S_LOAD_H: begin
                    state       <= S_LOAD_L;
                    set_freqH_A <= 1'b0;
                    set_freqL_A <= 1'b1;
                    freq_dout_A <= word_q[31:0];
                end
                S_LOAD_L: begin
                    state       <= S_ACK;
                    rx_sel_A    <= '0;
                    set_freqL_A <= 1'b0;
                    freq_dout_A <= '0;
                    ack_A       <= ONE << gnt;
                end
                S_ACK: begin
                    state    <= S_IDLE;
                    ack_A    <= '0;
                    last_gnt <= gnt;
                    busy_A   <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_A <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_freq_sched.sv
// Scoreboard bench for rx_freq_sched: stimulus pushes expected grants, a monitor
// pops and checks them whenever the DUT strobes or acks.
module tb_rx_freq_sched;

    localparam int NCH = 8;
    localparam int FB  = 48;
    localparam int TMO = 16;

    logic                     adc_clk;
    logic                     rst;
    logic [NCH-1:0]           req;
    logic [NCH-1:0][FB-1:0]   freq;
    logic                     sync_en;
    logic                     rx_avail;
    logic [NCH-1:0]           rx_sel_A;
    logic                     set_freqH_A;
    logic                     set_freqL_A;
    logic [31:0]              freq_dout_A;
    logic [NCH-1:0]           ack_A;
    logic                     busy_A;
    logic                     sync_tmo_A;

    rx_freq_sched #(.N_CHANS(NCH), .FREQ_BITS(FB), .SYNC_TMO(TMO)) dut (
        .adc_clk     (adc_clk),
        .rst         (rst),
        .req_A       (req),
        .freq_A      (freq),
        .sync_en_A   (sync_en),
        .rx_avail_A  (rx_avail),
        .rx_sel_A    (rx_sel_A),
        .set_freqH_A (set_freqH_A),
        .set_freqL_A (set_freqL_A),
        .freq_dout_A (freq_dout_A),
        .ack_A       (ack_A),
        .busy_A      (busy_A),
        .sync_tmo_A  (sync_tmo_A)
    );

    typedef struct {
        int            chan;
        logic [FB-1:0] word;
        longint        hcyc;   // expected LOAD_H cycle, -1 = not timed
        bit            abort;  // reset lands in LOAD_H, no L/ack follows
    } exp_t;

    exp_t          exp_q[$];
    logic [FB-1:0] wq[NCH][$];   // words each requester will present, in order
    int            ptr_m;
    int            n_chk;
    int            n_fail;
    longint        cyc;
    bit            avail_rand;

    initial adc_clk = 1'b0;
    always #5 adc_clk = ~adc_clk;

    initial cyc = 0;
    always @(posedge adc_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [NCH-1:0] oh(input int k);
        return NCH'(1) << k;
    endfunction

    function automatic logic [FB-1:0] rand_word();
        return FB'({$urandom(), $urandom()});
    endfunction

    // ---------------- monitor ----------------
    exp_t   cur;
    bit     in_flight;
    longint h_at;

    always @(negedge adc_clk) begin
        if (set_freqH_A) begin
            chk("H expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                chk("H sel", 64'(rx_sel_A), 64'(oh(cur.chan)));
                chk("H dout", 64'(freq_dout_A), 64'(32'(cur.word[FB-1:32])));
                chk("H lone strobe", 64'(set_freqL_A), 64'(0));
                if (cur.hcyc >= 0)
                    chk("H cycle", 64'(cyc), 64'(cur.hcyc));
                in_flight = !cur.abort;
                h_at      = cyc;
            end
        end else if (set_freqL_A) begin
            chk("L follows H", 64'({in_flight, cyc == h_at + 1}), 64'(2'b11));
            chk("L sel", 64'(rx_sel_A), 64'(oh(cur.chan)));
            chk("L dout", 64'(freq_dout_A), 64'(cur.word[31:0]));
        end else begin
            if (|ack_A) begin
                chk("ack follows L", 64'({in_flight, cyc == h_at + 2}), 64'(2'b11));
                chk("ack chan", 64'(ack_A), 64'(oh(cur.chan)));
                in_flight = 1'b0;
            end
            chk("idle sel/dout", 64'({rx_sel_A, freq_dout_A}), 64'(0));
        end
    end

    // ---------------- stimulus helpers ----------------
    // One cycle; requesters react to an ack by presenting their next word or dropping req.
    task automatic tick();
        logic [NCH-1:0] a;
        @(negedge adc_clk);
        a = ack_A;
        @(posedge adc_clk);
        #1;
        rx_avail = avail_rand ? ($urandom_range(3) == 0) : 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (a[k]) begin
                if (wq[k].size() > 0) freq[k] = wq[k].pop_front();
                else                  req[k]  = 1'b0;
            end
        end
    endtask

    // Reference: pending requesters served in circular order after the last grant.
    task automatic issue(input logic [NCH-1:0] mask, input bit sync, input longint h_first);
        int   idx[NCH];
        int   left, p, k, n;
        exp_t e;
        left = 0;
        for (int j = 0; j < NCH; j++) begin
            idx[j] = 0;
            left += wq[j].size();
        end
        p = ptr_m;
        n = 0;
        k = 0;
        while (left > 0) begin
            for (int s = 1; s <= NCH; s++) begin
                k = (p + s) % NCH;
                if (idx[k] < wq[k].size()) break;
            end
            e.chan  = k;
            e.word  = wq[k][idx[k]];
            e.hcyc  = (h_first < 0) ? -1 : h_first + 5 * n;
            e.abort = 1'b0;
            exp_q.push_back(e);
            idx[k]++;
            p = k;
            left--;
            n++;
        end
        ptr_m   = p;
        sync_en = sync;
        for (int j = 0; j < NCH; j++) begin
            if (mask[j]) begin
                freq[j] = wq[j].pop_front();
                req[j]  = 1'b1;
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !in_flight && !busy_A && req == '0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain within budget", 64'(n < budget), 64'(1));
    endtask

    // ---------------- main ----------------
    initial begin
        longint         t0;
        logic [FB-1:0]  wa, wb;
        logic [NCH-1:0] m;
        n_chk      = 0;
        n_fail     = 0;
        in_flight  = 1'b0;
        avail_rand = 1'b0;
        rst        = 1'b1;
        req        = '0;
        freq       = '0;
        sync_en    = 1'b0;
        rx_avail   = 1'b0;
        repeat (3) tick();
        chk("reset outputs", 64'({rx_sel_A, set_freqH_A, set_freqL_A, freq_dout_A, ack_A, busy_A, sync_tmo_A}), 64'(0));
        rst   = 1'b0;
        ptr_m = NCH - 1;
        tick();

        // all channels request, ch0 re-requests after its first ack
        for (int k = 0; k < NCH; k++) wq[k].push_back(rand_word());
        wq[0].push_back(rand_word());
        issue('1, 1'b0, cyc + 2);
        drain(200);

        // single request with a known word
        wq[2].push_back(48'h1234_89AB_CDEF);
        issue(NCH'(8'h04), 1'b0, cyc + 2);
        drain(50);

        // sync on: strobe during ARB is ignored, strobe 10 cycles after ARB loads next cycle
        t0 = cyc;
        wq[4].push_back(rand_word());
        issue(NCH'(8'h10), 1'b1, t0 + 12);
        tick();
        rx_avail = 1'b1;
        while (cyc < t0 + 11) tick();
        rx_avail = 1'b1;
        drain(50);
        chk("no timeout flag after synced load", 64'(sync_tmo_A), 64'(0));

        // sync on, no strobe: forced load after TMO wait cycles
        t0 = cyc;
        wq[6].push_back(rand_word());
        issue(NCH'(8'h40), 1'b1, t0 + 2 + TMO);
        while (cyc < t0 + 2 + TMO) tick();
        chk("timeout flag set", 64'(sync_tmo_A), 64'(1));
        drain(50);
        repeat (3) tick();
        chk("timeout flag sticky", 64'(sync_tmo_A), 64'(1));

        // request dropped while in ARB: back to IDLE, nothing loaded
        sync_en = 1'b0;
        req[1]  = 1'b1;
        freq[1] = rand_word();
        tick();
        chk("busy in ARB", 64'(busy_A), 64'(1));
        req[1] = 1'b0;
        tick();
        chk("idle after dropped req", 64'(busy_A), 64'(0));
        repeat (3) tick();

        // word changed during WAIT_SYNC: the latched word is loaded
        t0 = cyc;
        wa = rand_word();
        wb = ~wa;
        sync_en = 1'b1;
        freq[1] = wa;
        req[1]  = 1'b1;
        exp_q.push_back('{chan: 1, word: wa, hcyc: t0 + 6, abort: 1'b0});
        ptr_m = 1;
        tick(); tick(); tick();
        freq[1] = wb;
        tick(); tick();
        rx_avail = 1'b1;
        drain(50);

        // reset during LOAD_H of ch3 with ch3/ch5 pending (last grant was ch1)
        t0 = cyc;
        sync_en = 1'b0;
        wa = rand_word();
        wb = rand_word();
        freq[3] = wa;
        freq[5] = wb;
        req[3]  = 1'b1;
        req[5]  = 1'b1;
        exp_q.push_back('{chan: 3, word: wa, hcyc: t0 + 2, abort: 1'b1});
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("outputs cleared by reset", 64'({rx_sel_A, set_freqH_A, set_freqL_A, freq_dout_A, ack_A, busy_A, sync_tmo_A}), 64'(0));
        rst = 1'b0;
        t0  = cyc;
        exp_q.push_back('{chan: 3, word: wa, hcyc: t0 + 2, abort: 1'b0});
        exp_q.push_back('{chan: 5, word: wb, hcyc: t0 + 7, abort: 1'b0});
        ptr_m = 5;
        drain(100);

        // randomized request groups, sync on or off
        for (int g = 0; g < 25; g++) begin
            bit s;
            s = ($urandom_range(2) == 0);
            m = NCH'($urandom_range(1, (1 << NCH) - 1));
            for (int k = 0; k < NCH; k++)
                if (m[k]) repeat ($urandom_range(1, 3)) wq[k].push_back(rand_word());
            avail_rand = s;
            issue(m, s, s ? -1 : cyc + 2);
            drain(2000);
            avail_rand = 1'b0;
            tick();
        end

        chk("scoreboard empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
